// File: rtl/tx_logic_2.sv
// Router port transmitter: pops items from the output fifo and hands each to one of five
// receivers over per-port toggle handshakes. Optional macro: TX_ACK_SYNC_EN (2-flop ack sync).

`ifndef SIZE
`define SIZE 8
`endif

module tx_logic_2 #(
    parameter int id       = -1,
    parameter int PORT_LSB = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [`SIZE-1:0]     fifo_item_out,
    output logic                 fifo_read,
    output logic [4:0]           tx_req,
    input  logic [4:0]           tx_ack,
    output logic [`SIZE*5-1:0]   tx_data,
    output logic [7:0]           drop_count
);

    localparam int NPORTS = 5;
    localparam int W      = `SIZE;

    // id is only a trace tag; -1 means "not assigned", anything lower is a wiring mistake.
    generate
        if (PORT_LSB < 0 || PORT_LSB + 3 > W || id < -1) begin : g_bad_cfg
            $error("tx_logic_2 id %0d: bad configuration (destination field outside item)", id);
        end
    endgenerate

    logic [4:0] ack_v;

`ifdef TX_ACK_SYNC_EN
    logic [4:0] ack_meta_reg;
    logic [4:0] ack_sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_meta_reg <= '0;
            ack_sync_reg <= '0;
        end else begin
            ack_meta_reg <= tx_ack;
            ack_sync_reg <= ack_meta_reg;
        end
    end

    assign ack_v = ack_sync_reg;
`else
    assign ack_v = tx_ack;
`endif

    logic [2:0] dest;
    logic       head_valid;
    logic       dest_valid;
    logic [4:0] port_busy;
    logic [4:0] port_hit;
    logic       issue;
    logic       drop;
    logic [7:0] drop_count_reg;

    assign dest       = fifo_item_out[PORT_LSB +: 3];
    assign head_valid = !fifo_empty;
    assign dest_valid = (dest <= 3'd4);

    // Each port owns its request toggle and data slice; the head item only waits on its own port.
    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            logic         req_reg;
            logic [W-1:0] data_reg;

            assign port_busy[gi] = req_reg ^ ack_v[gi];
            assign port_hit[gi]  = head_valid && (dest == 3'(gi)) && !port_busy[gi];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    req_reg  <= 1'b0;
                    data_reg <= '0;
                end else if (port_hit[gi]) begin
                    req_reg  <= ~req_reg;
                    data_reg <= fifo_item_out;
                end
            end

            assign tx_req[gi]          = req_reg;
            assign tx_data[W*gi +: W]  = data_reg;
        end
    endgenerate

    assign issue     = |port_hit;
    assign drop      = head_valid && !dest_valid;
    assign fifo_read = reset && (issue || drop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count_reg <= '0;
        end else if (drop && drop_count_reg != 8'hFF) begin
            drop_count_reg <= drop_count_reg + 8'd1;
        end
    end

    assign drop_count = drop_count_reg;

endmodule
